// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory path.
// Holds the access-size encodings, the LSU FSM state type and the byte-lane
// mask constants. The lane masks use the same read_en encoding as the
// downstream load-extend stage, so ld_ren can be passed to it unchanged.
package mem_pkg;

    // Access size encodings as driven by the EX/MEM register
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    // Byte-lane masks, bit n = byte lane n of the 32-bit word
    localparam logic [3:0] LANE_B0 = 4'b0001;
    localparam logic [3:0] LANE_B1 = 4'b0010;
    localparam logic [3:0] LANE_B2 = 4'b0100;
    localparam logic [3:0] LANE_B3 = 4'b1000;
    localparam logic [3:0] LANE_H0 = 4'b0011;
    localparam logic [3:0] LANE_H1 = 4'b1100;
    localparam logic [3:0] LANE_W  = 4'b1111;

endpackage

// File: rtl/lsu_lane_gen.sv
// Combinational byte-lane generator for a 32-bit data bus.
// Ports:
//   size      in  2   access size (SZ_BYTE/SZ_HALF/SZ_WORD, 11 behaves as word)
//   addr_lo   in  2   low two address bits
//   wdata     in  32  right-aligned store data
//   mask      out 4   byte-lane mask
//   wdata_rep out 32  store data replicated across all lanes
//   misalign  out 1   access not naturally aligned for its size
module lsu_lane_gen
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  mask,
    output logic [31:0] wdata_rep,
    output logic        misalign
);

    always_comb begin
        mask      = LANE_W;
        wdata_rep = wdata;
        misalign  = 1'b0;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'b00:   mask = LANE_B0;
                    2'b01:   mask = LANE_B1;
                    2'b10:   mask = LANE_B2;
                    default: mask = LANE_B3;
                endcase
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                mask      = addr_lo[1] ? LANE_H1 : LANE_H0;
                wdata_rep = {2{wdata[15:0]}};
                misalign  = addr_lo[0];
            end
            // word, and the illegal 11 encoding which is treated as word
            default: begin
                mask      = LANE_W;
                wdata_rep = wdata;
                misalign  = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage between EX/MEM and the data bus.
// Decodes size/address into byte lanes, flags misaligned accesses, runs the
// req / addr_ok / data_ok handshake and stalls upstream while a transfer is
// outstanding. Load results leave as raw bus data plus lane mask and sign.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   mem_en/wr/size/sign/addr/wdata  memory op from EX/MEM
//   flush                           cancel current and incoming op
//   stall                           freeze upstream
//   adel, ades, badvaddr            address-error report (combinational)
//   data_req/wr/size/addr/wdata/wstrb  bus request side
//   data_addr_ok, data_data_ok, data_rdata  bus response side
//   ld_valid, ld_rdata, ld_ren, ld_sign     to the load-extend stage
module lsu_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic              mem_wr,
    input  logic [1:0]        mem_size,
    input  logic              mem_sign,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              flush,
    output logic              stall,
    output logic              adel,
    output logic              ades,
    output logic [ADDR_W-1:0] badvaddr,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic [3:0]        ld_ren,
    output logic              ld_sign
);

    lsu_state_e        state;
    logic              cancel;
    logic [3:0]        lane_mask;
    logic [DATA_W-1:0] lane_wdata;
    logic              misalign;
    logic              in_idle;
    logic              accept;
    logic              fault;

    lsu_lane_gen u_lane_gen (
        .size      (mem_size),
        .addr_lo   (mem_addr[1:0]),
        .wdata     (mem_wdata),
        .mask      (lane_mask),
        .wdata_rep (lane_wdata),
        .misalign  (misalign)
    );

    assign in_idle = (state == IDLE);
    assign accept  = in_idle & mem_en & ~misalign & ~flush;
    // A flushed incoming op is cancelled, so it cannot fault either
    assign fault   = in_idle & mem_en & misalign & ~flush;

    assign adel     = fault & ~mem_wr;
    assign ades     = fault & mem_wr;
    assign badvaddr = fault ? mem_addr : '0;

    assign stall    = accept | (state == REQ) | (state == WAIT);

    // Flush arriving in DONE must still kill this cycle's result
    assign ld_valid = (state == DONE) & ~data_wr & ~cancel & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cancel     <= 1'b0;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'b00;
            data_addr  <= '0;
            data_wdata <= '0;
            data_wstrb <= 4'b0000;
            ld_rdata   <= '0;
            ld_ren     <= 4'b0000;
            ld_sign    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= REQ;
                        data_req   <= 1'b1;
                        data_wr    <= mem_wr;
                        data_size  <= mem_size;
                        data_addr  <= mem_addr;
                        data_wdata <= lane_wdata;
                        data_wstrb <= mem_wr ? lane_mask : 4'b0000;
                        ld_ren     <= lane_mask;
                        ld_sign    <= mem_sign & ~mem_wr;
                    end
                end
                REQ: begin
                    // The bus transaction is never abandoned; flush only
                    // marks the result as unwanted.
                    if (flush) cancel <= 1'b1;
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) cancel <= 1'b1;
                    if (data_data_ok) begin
                        ld_rdata <= data_rdata;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    cancel <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control stage for the MIPS data-memory path, between the EX/MEM pipeline register and the data SRAM-like bus. It decodes access size and address into byte lanes, checks alignment, and runs the request/address-ok/data-ok handshake. It stalls the pipeline while a transfer is outstanding, then hands raw read data plus the matching 4-bit lane mask and sign flag to the downstream load-extend stage.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; fixed at 32, lane logic assumes 4 bytes
---
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- mem_en  in  1  valid memory op from EX/MEM this cycle
- mem_wr  in  1  1 = store, 0 = load
- mem_size  in  2  00 byte, 01 half, 10 word; 11 illegal, treated as word
- mem_sign  in  1  load sign-extend request; ignored for stores
- mem_addr  in  32  virtual/physical byte address
- mem_wdata  in  32  store data, right-aligned
- flush  in  1  cancel current and incoming op (exception/eret)
- stall  out  1  freeze upstream stages
- adel / ades  out  1 each  load / store address-error, one cycle, with the offending op
- badvaddr  out  32  mem_addr of the faulting op
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  copy of mem_size
- data_addr  out  32  latched address
- data_wdata  out  32  lane-replicated store data
- data_wstrb  out  4  byte strobes; 0000 for loads
- data_addr_ok  in  1  bus accepted request
- data_data_ok  in  1  bus returned data / write ack
- data_rdata  in  32  bus read data
- ld_valid  out  1  one-cycle pulse: load result ready
- ld_rdata  out  32  raw bus word, unshifted
- ld_ren  out  4  lane mask for the extend stage
- ld_sign  out  1  sign flag for the extend stage

## Operation
- Lane mask: byte → 0001 << addr[1:0]; half → addr[1] ? 1100 : 0011; word → 1111.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠00. Misaligned ops raise adel/ades, badvaddr=mem_addr, issue no bus request, and do not stall.
- Store data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word unchanged. wstrb = lane mask.
- FSM states IDLE, REQ, WAIT, DONE:
  - IDLE → REQ on mem_en & aligned & ~flush; latch addr, size, wr, sign, mask, wdata.
  - REQ: data_req=1; → WAIT on data_addr_ok.
  - WAIT: → DONE on data_data_ok; latch data_rdata.
  - DONE: → IDLE unconditionally.
- ld_valid=1 in DONE, for loads only, and only if the op was not cancelled.
- stall = (IDLE & mem_en & aligned & ~flush) | REQ | WAIT.
- Flush in REQ/WAIT sets a cancel flag: the bus transaction still completes, data_req stays high until addr_ok, and ld_valid is suppressed. Flush in DONE suppresses that cycle's ld_valid.
- The cancel flag clears on return to IDLE.

## Timing
- Reset values: state=IDLE; all outputs 0, including ld_ren=0000, data_wstrb=0000, stall=0; cancel=0.
- Op presented cycle T: data_req high from T+1; data_addr/wstrb/wdata stable until addr_ok.
- Earliest data_data_ok is the cycle after addr_ok. Best-case load: ld_valid at T+3; stall high T..T+2, low at T+3.
- Upstream holds mem_* stable while stall=1. A new op is accepted the cycle after DONE.
- addr_ok with no req is ignored. data_ok outside WAIT is ignored.
- rst mid-transaction: return to IDLE next edge, req dropped. The bus is reset by the same rst.
- Exceptions (adel/ades) are combinational from inputs in IDLE, with no latency.

## Structure
- Shared package mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state encoding
  - lane-mask constants 0001/0010/0100/1000/0011/1100/1111, matching the load-extend stage's read_en encoding
- One sub-module, lsu_lane_gen (combinational): takes size, addr[1:0] and wdata; produces mask, replicated wdata and the misalign flag. It is reused by the store path.

## Test plan
- LW at 0x1000, addr_ok same cycle as req, data_ok next cycle with 0x8899AABB → ld_valid at T+3, ld_ren=1111, ld_rdata=0x8899AABB, stall low at T+3.
- LB sign at 0x1003, rdata 0x80123456 → ld_ren=1000, ld_sign=1, data_wstrb=0000.
- SH at 0x2002, wdata 0x0000BEEF → data_wdata=0xBEEFBEEF, data_wstrb=1100, data_wr=1, no ld_valid.
- LH at 0x2001 → adel=1, badvaddr=0x2001, data_req never high, stall=0.
- Flush in WAIT, with addr_ok delayed 3 cycles and data_ok delayed 2 → transaction completes, ld_valid stays 0, FSM back in IDLE.
- rst asserted in REQ → next cycle state IDLE, data_req=0, stall=0.
